huffman_bit_packer: RTL and testbench
=====================================

# huffman_bit_packer

Downstream stage of the Huffman encoder. Takes one variable-length codeword per handshake (right-aligned code plus its bit length) and packs the codewords MSB-first into a continuous bitstream. It emits that stream as bytes over a valid/ready interface toward the output buffer or UART. A flush request pads the final partial byte with zeros and tags it, so the decoder side knows where the stream ends.

## Interface
- Parameters: none. Widths are fixed: code 16, length 5, output 8, buffer 32.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  block enable; low freezes all state.
- in_valid  in  1  codeword present.
- in_ready  out  1  packer can accept a codeword this cycle.
- in_code  in  16  codeword, right-aligned; bit [in_len-1] is sent first.
- in_len  in  5  codeword length. 0 means no bits; values 17..31 are clamped to 16.
- in_flush  in  1  request to drain and pad; sampled only in RUN.
- out_valid  out  1  byte available.
- out_ready  in  1  consumer takes the byte.
- out_data  out  8  packed byte, first bit in bit 7.
- out_last  out  1  marks the final byte of a flush.
- out_pad  out  3  number of zero pad bits in the out_last byte (0..7). It is 0 on all other bytes.
- flush_done  out  1  one-cycle pulse when a flush completes.
- byte_cnt  out  16  bytes handed off since reset; wraps at 65535 -> 0.

## Operation
- State: 32-bit left-aligned bit buffer `buf` and 6-bit fill count `cnt` (0..32). Valid bits occupy buf[31:32-cnt].
- FSM states: RUN, FLUSH.
  - RUN -> FLUSH when in_flush = 1 while enable = 1.
  - FLUSH -> RUN when cnt = 0. In that same cycle flush_done = 1.
- in_ready = enable & (state == RUN) & (cnt <= 16) & !rst.
- Accept condition: in_valid & in_ready. The low L = min(in_len, 16) bits of in_code are appended directly after the existing valid bits.
- out_valid = enable & ((cnt >= 8) | (state == FLUSH & cnt > 0)).
- out_data = buf[31:24]. Bits at or beyond cnt read as 0, because vacated buffer bits are always cleared.
- Emit condition: out_valid & out_ready. On emit, buf shifts left by 8 with zero fill, cnt = max(cnt - 8, 0), and byte_cnt increments.
- Simultaneous accept and emit in one cycle: shift first, then append at the post-shift position. The new cnt is cnt - 8 + L.
- out_last = (state == FLUSH) & (cnt <= 8) & (cnt > 0).
- out_pad = out_last ? 8 - cnt : 0, evaluated mod 8, so cnt = 8 gives 0.
- While in FLUSH, no codewords are accepted; in_flush is ignored.
- Flush with cnt = 0: the block enters FLUSH, then on the next cycle pulses flush_done and returns to RUN. No byte is emitted.
- enable = 0: in_ready = 0 and out_valid = 0; buf, cnt, state and byte_cnt hold. in_flush is ignored.
- in_valid with in_len = 0 is consumed with no effect on buf or cnt.

## Timing
- Reset values: buf = 0, cnt = 0, state = RUN, out_valid = 0, out_data = 0x00, out_last = 0, out_pad = 0, flush_done = 0, byte_cnt = 0.
- in_ready is low during the rst cycle. It is high on the first cycle after reset if enable = 1.
- Latency: a codeword accepted at edge N that brings cnt to 8 or more gives out_valid = 1 after edge N, i.e. visible in cycle N+1.
- Throughput: one codeword and one byte per cycle, sustainable while the average code length is 8 bits or less.
- Backpressure: with out_ready = 0, codewords are accepted until cnt > 16; in_ready then stays low.
- out_data, out_last and out_pad stay stable while out_valid = 1 and out_ready = 0.
- flush_done is high for exactly one cycle: the cycle in which the FSM observes cnt = 0 in FLUSH. That is one cycle after the last-byte emit edge.
- rst asserted mid-flush or mid-stream clears everything at that edge. No partial byte is emitted.

## Test plan
- Reset and idle: after rst, with enable = 1 and out_ready = 1 -> out_valid = 0, in_ready = 1, byte_cnt = 0.
- Packing across a boundary: code 3'b101 (len 3), then 5'b11001 (len 5) -> one cycle after the second accept, out_data = 0xB9 with out_valid = 1; byte_cnt = 1 after the handshake.
- Full-width code: 16'hA5C3 (len 16) with out_ready = 1 -> 0xA5 then 0xC3 on consecutive cycles; cnt returns to 0.
- Backpressure: out_ready = 0, feed 16'hFFFF (len 16) continuously -> exactly two accepts, then in_ready = 0 with cnt = 32. Raising out_ready drains bytes 0xFF; in_ready returns once cnt <= 16.
- Flush with partial byte: 4'b1101 (len 4), then in_flush -> out_data = 0xD0, out_last = 1, out_pad = 4. flush_done pulses one cycle after the handshake, then in_ready = 1.
- Freeze and reset mid-operation: drop enable with cnt = 12 -> no activity and state holds. Re-raise enable -> resumes with the same byte. Assert rst during FLUSH -> all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/huffman_bit_packer_if.sv
// Codeword-in / byte-out handshake bundle for the Huffman bit packer.
// master drives codewords and consumes bytes; slave is the packer.
interface huffman_bit_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_code;
  logic [4:0]  in_len;
  logic        in_flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [2:0]  out_pad;

  modport master (
    output in_valid, in_code, in_len, in_flush, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_pad
  );

  modport slave (
    input  in_valid, in_code, in_len, in_flush, out_ready,
    output in_ready, out_valid, out_data, out_last, out_pad
  );
endinterface

// File: rtl/huffman_bit_packer.sv
// Packs right-aligned variable-length codewords MSB-first into bytes,
// with a zero-padding flush that tags the final byte.
module huffman_bit_packer (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  huffman_bit_packer_if.slave         bus,
  output logic                        flush_done,
  output logic [15:0]                 byte_cnt
);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] buf_q, buf_d, buf_s, app;
  logic [5:0]  cnt_q, cnt_d, cnt_s;
  logic [15:0] bcnt_q, bcnt_d;
  logic [4:0]  len;
  logic        acc, emit;
  logic        in_flush_st;

  assign in_flush_st = (state_q == FLUSH);
  assign len = (bus.in_len > 5'd16) ? 5'd16 : bus.in_len;

  assign bus.in_ready = enable & ~in_flush_st
                      & (cnt_q <= 6'd16) & ~rst;
  assign bus.out_valid = enable
                       & ((cnt_q >= 6'd8)
                       | (in_flush_st & (cnt_q != 6'd0)));
  assign bus.out_data = buf_q[31:24];
  assign bus.out_last = in_flush_st & (cnt_q <= 6'd8)
                      & (cnt_q != 6'd0);
  assign bus.out_pad = bus.out_last
                     ? 3'(6'd8 - cnt_q) : 3'd0;

  assign acc  = bus.in_valid & bus.in_ready;
  assign emit = bus.out_valid & bus.out_ready;
  assign byte_cnt = bcnt_q;

  // Shift out first, then append the new code just below the survivors.
  always_comb begin
    buf_s = buf_q;
    cnt_s = cnt_q;
    if (emit) begin
      buf_s = {buf_q[23:0], 8'h00};
      cnt_s = (cnt_q >= 6'd8) ? cnt_q - 6'd8 : 6'd0;
    end
    app = ({bus.in_code, 16'h0000} << (5'd16 - len)) >> cnt_s;
    buf_d = buf_s;
    cnt_d = cnt_s;
    if (acc) begin
      buf_d = buf_s | app;
      cnt_d = cnt_s + {1'b0, len};
    end
    bcnt_d = bcnt_q + {15'd0, emit};
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    unique case (state_q)
      RUN: begin
        if (enable & bus.in_flush) state_d = FLUSH;
      end
      FLUSH: begin
        if (enable & (cnt_q == 6'd0)) begin
          state_d    = RUN;
          flush_done = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      buf_q   <= 32'd0;
      cnt_q   <= 6'd0;
      bcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed plus randomized bench for huffman_bit_packer against a
// bit-queue reference model.
module tb_huffman_bit_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        flush_done;
  logic [15:0] byte_cnt;

  huffman_bit_packer_if bus();

  huffman_bit_packer dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .bus        (bus.slave),
    .flush_done (flush_done),
    .byte_cnt   (byte_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: pending stream bits, oldest first.
  bit          mq[$];
  bit          mflush;
  logic [15:0] mbytes;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(bit v, logic [15:0] c, logic [4:0] l,
                       bit f, bit r);
    bus.in_valid  = v;
    bus.in_code   = c;
    bus.in_len    = l;
    bus.in_flush  = f;
    bus.out_ready = r;
  endtask

  task automatic cycle();
    int          sz;
    bit          e_rdy, e_val, e_last, e_done;
    logic [7:0]  e_data;
    logic [2:0]  e_pad;
    int          l;
    @(negedge clk);
    sz     = mq.size();
    e_rdy  = enable && !mflush && sz <= 16 && !rst;
    e_val  = enable && (sz >= 8 || (mflush && sz > 0));
    e_last = mflush && sz > 0 && sz <= 8;
    e_pad  = e_last ? 3'((8 - sz) % 8) : 3'd0;
    e_done = enable && mflush && sz == 0;
    e_data = 8'h00;
    for (int i = 0; i < 8; i++)
      if (i < sz) e_data[7-i] = mq[i];
    chk("in_ready", 32'(bus.in_ready), 32'(e_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(e_val));
    chk("out_data", 32'(bus.out_data), 32'(e_data));
    chk("out_last", 32'(bus.out_last), 32'(e_last));
    chk("out_pad", 32'(bus.out_pad), 32'(e_pad));
    chk("flush_done", 32'(flush_done), 32'(e_done));
    chk("byte_cnt", 32'(byte_cnt), 32'(mbytes));
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mflush = 0;
      mbytes = 16'd0;
    end else if (enable) begin
      if (e_val && bus.out_ready) begin
        for (int i = 0; i < 8 && mq.size() > 0; i++)
          void'(mq.pop_front());
        mbytes = mbytes + 16'd1;
      end
      if (e_rdy && bus.in_valid) begin
        l = (bus.in_len > 16) ? 16 : int'(bus.in_len);
        for (int i = l - 1; i >= 0; i--)
          mq.push_back(bus.in_code[i]);
      end
      if (!mflush && bus.in_flush) mflush = 1;
      else if (mflush && sz == 0) mflush = 0;
    end
    #1;
  endtask

  initial begin
    mflush = 0;
    mbytes = 16'd0;
    rst    = 1'b1;
    enable = 1'b1;
    drive(0, 16'h0, 5'd0, 0, 1);
    @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(bus.in_ready), 32'd1);
    chk("idle_valid", 32'(bus.out_valid), 32'd0);
    chk("idle_bcnt", 32'(byte_cnt), 32'd0);

    // Two codewords crossing a byte boundary.
    drive(1, 16'h0005, 5'd3, 0, 1);
    cycle();
    drive(1, 16'h0019, 5'd5, 0, 1);
    cycle();
    drive(0, 16'h0, 5'd0, 0, 1);
    #1;
    chk("pack_data", 32'(bus.out_data), 32'hB9);
    chk("pack_valid", 32'(bus.out_valid), 32'd1);
    cycle();
    chk("pack_bcnt", 32'(byte_cnt), 32'd1);

    // Full-width code drains on consecutive cycles.
    drive(1, 16'hA5C3, 5'd16, 0, 1);
    cycle();
    drive(0, 16'h0, 5'd0, 0, 1);
    #1;
    chk("full_b0", 32'(bus.out_data), 32'hA5);
    cycle();
    chk("full_b1", 32'(bus.out_data), 32'hC3);
    cycle();
    chk("full_empty", 32'(bus.out_valid), 32'd0);

    // Backpressure: two accepts fill the buffer.
    drive(1, 16'hFFFF, 5'd16, 0, 0);
    repeat (4) cycle();
    chk("bp_ready", 32'(bus.in_ready), 32'd0);
    drive(0, 16'h0, 5'd0, 0, 1);
    repeat (2) cycle();
    chk("bp_resume", 32'(bus.in_ready), 32'd1);
    repeat (2) cycle();

    // Flush of a partial byte.
    drive(1, 16'h000D, 5'd4, 0, 1);
    cycle();
    drive(0, 16'h0, 5'd0, 1, 1);
    cycle();
    drive(0, 16'h0, 5'd0, 0, 1);
    #1;
    chk("fl_data", 32'(bus.out_data), 32'hD0);
    chk("fl_last", 32'(bus.out_last), 32'd1);
    chk("fl_pad", 32'(bus.out_pad), 32'd4);
    cycle();
    chk("fl_done", 32'(flush_done), 32'd1);
    cycle();
    chk("fl_ready", 32'(bus.in_ready), 32'd1);

    // Freeze with 12 bits held, then resume.
    drive(1, 16'h0ABC, 5'd12, 0, 0);
    cycle();
    enable = 1'b0;
    drive(1, 16'hFFFF, 5'd8, 1, 1);
    #1;
    chk("frz_valid", 32'(bus.out_valid), 32'd0);
    chk("frz_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) cycle();
    enable = 1'b1;
    drive(0, 16'h0, 5'd0, 0, 1);
    #1;
    chk("frz_data", 32'(bus.out_data), 32'hAB);
    cycle();
    drive(0, 16'h0, 5'd0, 1, 0);
    cycle();
    drive(0, 16'h0, 5'd0, 0, 1);
    #1;
    chk("rf_data", 32'(bus.out_data), 32'hC0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("rf_valid", 32'(bus.out_valid), 32'd0);
    chk("rf_last", 32'(bus.out_last), 32'd0);
    chk("rf_bcnt", 32'(byte_cnt), 32'd0);
    chk("rf_done", 32'(flush_done), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 9) != 0);
      drive($urandom_range(0, 2) != 0,
            16'($urandom),
            ($urandom_range(0, 1) != 0)
              ? 5'($urandom_range(0, 8))
              : 5'($urandom_range(0, 31)),
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
